// File: rtl/vic_fiq_ctrl.sv
// -----------------------------------------------------------------------------
// vic_fiq_ctrl
//
// FIQ request path of the vectored interrupt controller. Each source is
// sampled into a two-stage register chain. In edge mode a rising edge of the
// sampled line sets a sticky latch. Software clears the latch with a
// write-1-to-clear pulse, or the core clears it by acknowledging the reported
// source. In level mode the sampled line is reported directly. The masked
// pending set is reduced to a registered valid flag, a registered request
// (gated by the global FIQ enable) and the registered index of the
// lowest-numbered pending source.
//
// Parameters
//   NUM_SRC        number of interrupt sources (2..32)
//   ID_W           width of the source ID, derived from NUM_SRC
//
// Ports
//   HCLK           clock; every state update happens on its rising edge
//   HRESETn        synchronous active-low reset
//   VICIntSource   raw interrupt lines, active-high, synchronous to HCLK
//   VICEdgeSel     per-source mode: 1 = rising-edge, 0 = level
//   VICIntEnable   per-source mask, 1 = enabled
//   VICFIQEn       global FIQ enable
//   VICIntClear    one-cycle write-1-to-clear pulses for the edge latches
//   VICFIQAck      acknowledge of the currently reported source
//   VICRawStatus   unmasked pending status
//   VICFIQStatus   pending status masked by VICIntEnable
//   VICFIQRequest  registered FIQ request
//   VICFIQValid    registered: some masked source is pending
//   VICFIQId       registered index of the lowest pending source
// -----------------------------------------------------------------------------
module vic_fiq_ctrl #(
  parameter int  NUM_SRC = 32,
  localparam int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [NUM_SRC-1:0] VICIntSource,
  input  logic [NUM_SRC-1:0] VICEdgeSel,
  input  logic [NUM_SRC-1:0] VICIntEnable,
  input  logic               VICFIQEn,
  input  logic [NUM_SRC-1:0] VICIntClear,
  input  logic               VICFIQAck,
  output logic [NUM_SRC-1:0] VICRawStatus,
  output logic [NUM_SRC-1:0] VICFIQStatus,
  output logic               VICFIQRequest,
  output logic               VICFIQValid,
  output logic [ID_W-1:0]    VICFIQId
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] src_q;    // first sample of the source lines
  logic [NUM_SRC-1:0] src_qq;   // previous sample, for rising-edge detection
  logic [NUM_SRC-1:0] edge_q;   // sticky edge latches
  logic [NUM_SRC-1:0] edge_d;
  logic               req_q;
  logic               req_d;
  logic               valid_q;
  logic               valid_d;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    id_d;

  // ---------------------------------------------------------------------------
  // Combinational status
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] ack_hit;
  logic [NUM_SRC-1:0] raw_status;
  logic [NUM_SRC-1:0] fiq_status;

  assign rise       = src_q & ~src_qq;
  assign raw_status = (VICEdgeSel & edge_q) | (~VICEdgeSel & src_q);
  assign fiq_status = raw_status & VICIntEnable;

  // An acknowledge only counts while a request is actually being presented;
  // it then targets the source named by the registered ID.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    ack_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_hit[i] = VICFIQAck & req_q & (id_q == ID_W'(i));
    end
  end

  // Edge latch next state. A new edge wins over a clear or acknowledge in the
  // same cycle so that it is never lost. Level-mode bits are held at zero,
  // which also discards a pending latch when a source leaves edge mode.
  assign edge_d = VICEdgeSel & (rise | (edge_q & ~VICIntClear & ~ack_hit));

  // Lowest-index priority encoder over the masked status. Scanning from the
  // top down lets the lowest set bit write last and win.
  always_comb begin
    id_d = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      // NOTE: blocking assignment is correct here; inside combinational logic
      // each loop iteration must see the value written by the one before it.
      if (fiq_status[i]) id_d = ID_W'(i);
    end
  end

  assign valid_d = |fiq_status;
  assign req_d   = VICFIQEn & valid_d;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      // NOTE: every state element, including the per-source vectors, is reset;
      // a reset must discard all pending edges and sampled history.
      src_q   <= '0;
      src_qq  <= '0;
      edge_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the
      // pre-edge values, giving a true two-stage sampling chain.
      src_q   <= VICIntSource;
      src_qq  <= src_q;
      edge_q  <= edge_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign VICRawStatus  = raw_status;
  assign VICFIQStatus  = fiq_status;
  assign VICFIQRequest = req_q;
  assign VICFIQValid   = valid_q;
  assign VICFIQId      = id_q;

endmodule

// File: tb/tb_vic_fiq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vic_fiq_ctrl
//
// Directed bench for vic_fiq_ctrl. Three instances: NUM_SRC = 32 (main),
// 2 and 17 (width / highest-source checks). The stimulus process drives
// inputs just after each rising edge and pushes hand-computed expectations,
// tagged with the edge number they refer to, into a scoreboard queue. A
// separate monitor compares them on the falling edge of that cycle.
// -----------------------------------------------------------------------------
module tb_vic_fiq_ctrl;

  typedef enum int {
    F_REQ, F_VALID, F_ID, F_RAW, F_STAT,
    F_REQ2, F_ID2, F_REQ17, F_ID17
  } field_e;

  typedef struct {
    int          cyc;
    field_e      f;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_miss = 0;

  logic clk = 1'b0;
  logic rstn;

  // main instance
  logic [31:0] src, sel, en, clr;
  logic        fiqen, ack;
  logic [31:0] raw, stat;
  logic        req, valid;
  logic [4:0]  id;

  // NUM_SRC = 2
  logic [1:0]  src2, raw2, stat2;
  logic        req2, valid2;
  logic        id2;

  // NUM_SRC = 17
  logic [16:0] src17, raw17, stat17;
  logic        req17, valid17;
  logic [4:0]  id17;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vic_fiq_ctrl #(.NUM_SRC(32)) dut (
    .HCLK(clk), .HRESETn(rstn),
    .VICIntSource(src), .VICEdgeSel(sel), .VICIntEnable(en),
    .VICFIQEn(fiqen), .VICIntClear(clr), .VICFIQAck(ack),
    .VICRawStatus(raw), .VICFIQStatus(stat),
    .VICFIQRequest(req), .VICFIQValid(valid), .VICFIQId(id)
  );

  vic_fiq_ctrl #(.NUM_SRC(2)) dut2 (
    .HCLK(clk), .HRESETn(rstn),
    .VICIntSource(src2), .VICEdgeSel(2'b00), .VICIntEnable(2'b11),
    .VICFIQEn(1'b1), .VICIntClear(2'b00), .VICFIQAck(1'b0),
    .VICRawStatus(raw2), .VICFIQStatus(stat2),
    .VICFIQRequest(req2), .VICFIQValid(valid2), .VICFIQId(id2)
  );

  vic_fiq_ctrl #(.NUM_SRC(17)) dut17 (
    .HCLK(clk), .HRESETn(rstn),
    .VICIntSource(src17), .VICEdgeSel(17'h0), .VICIntEnable(17'h1ffff),
    .VICFIQEn(1'b1), .VICIntClear(17'h0), .VICFIQAck(1'b0),
    .VICRawStatus(raw17), .VICFIQStatus(stat17),
    .VICFIQRequest(req17), .VICFIQValid(valid17), .VICFIQId(id17)
  );

  function automatic logic [31:0] actual(field_e f);
    case (f)
      F_REQ:   return 32'(req);
      F_VALID: return 32'(valid);
      F_ID:    return 32'(id);
      F_RAW:   return raw;
      F_STAT:  return stat;
      F_REQ2:  return 32'(req2);
      F_ID2:   return 32'(id2);
      F_REQ17: return 32'(req17);
      F_ID17:  return 32'(id17);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: compare every expectation that belongs to the current edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [31:0] a;
        a = actual(sb[i].f);
        n_vec++;
        if (a !== sb[i].exp) begin
          n_miss++;
          $display("FAIL %s @edge %0d: got %h expected %h",
                   sb[i].name, cyc, a, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // off = 0 means the outputs after the edge just taken; off = n means n
  // edges later.
  task automatic check(input int off, input field_e f, input logic [31:0] v,
                       input string name);
    exp_t e;
    e.cyc  = cyc + off;
    e.f    = f;
    e.exp  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  // Immediate comparison of a live output against its expected value.
  task automatic check_now(input logic [31:0] got, input logic [31:0] v,
                           input string name);
    n_vec++;
    if (got !== v) begin
      n_miss++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, cyc, got, v);
    end
  endtask

  logic [31:0] lvl_pat [4] = '{32'h4a0000a4, 32'h4a0000a4, 32'hffffffff, 32'h4a000000};
  int          lvl_id  [4] = '{2, 2, 2, 25};

  initial begin
    rstn  = 1'b0;
    src   = '1;
    sel   = '1;
    en    = '1;
    clr   = '0;
    fiqen = 1'b1;
    ack   = 1'b0;
    src2  = 2'b10;
    src17 = 17'h10000;

    // ---------------- reset with every source high --------------------------
    repeat (3) tick();
    check_now(32'(req),   32'd0, "rst_req_now");
    check_now(32'(id),    32'd0, "rst_id_now");
    check_now(raw,        32'd0, "rst_raw_now");
    check_now(32'(valid), 32'd0, "rst_valid_now");
    check(0, F_REQ,   32'd0, "rst_req");
    check(0, F_ID,    32'd0, "rst_id");
    check(0, F_VALID, 32'd0, "rst_valid");
    check(0, F_RAW,   32'd0, "rst_raw");
    check(0, F_STAT,  32'd0, "rst_stat");
    rstn = 1'b1;
    // sources already high at release are treated as rising edges
    check(1, F_RAW,   32'd0,        "rel_raw_e1");
    check(2, F_RAW,   32'hffffffff, "rel_raw_e2");
    check(2, F_REQ,   32'd0,        "rel_req_e2");
    check(3, F_REQ,   32'd1,        "rel_req_e3");
    check(3, F_ID,    32'd0,        "rel_id_e3");
    check(3, F_VALID, 32'd1,        "rel_valid_e3");
    // small instances: level mode, highest source alone
    check(2, F_REQ2,  32'd1,  "p2_req_hi");
    check(2, F_ID2,   32'd1,  "p2_id_hi");
    check(2, F_REQ17, 32'd1,  "p17_req_hi");
    check(2, F_ID17,  32'd16, "p17_id_hi");
    repeat (3) tick();

    src2  = 2'b00;
    src17 = 17'h10010;
    check(2, F_REQ2, 32'd0, "p2_req_lo");
    check(2, F_ID2,  32'd0, "p2_id_lo");
    check(2, F_ID17, 32'd4, "p17_id_lowest");

    // ---------------- level path -------------------------------------------
    src = '0;
    sel = '0;
    en  = 32'h4a0000a4;
    repeat (3) tick();
    src17 = '0;
    check(2, F_REQ17, 32'd0, "p17_req_lo");

    for (int p = 0; p < 4; p++) begin
      src   = lvl_pat[p];
      fiqen = (p % 2 == 0);
      check(1, F_RAW,   lvl_pat[p],                 "lvl_raw");
      check(1, F_STAT,  lvl_pat[p] & 32'h4a0000a4,  "lvl_stat");
      check(2, F_REQ,   32'(p % 2 == 0),            "lvl_req");
      check(2, F_VALID, 32'd1,                      "lvl_valid");
      check(2, F_ID,    32'(lvl_id[p]),             "lvl_id");
      tick();
      src = '0;
      check(1, F_RAW,   32'd0, "lvl_raw_off");
      check(2, F_REQ,   32'd0, "lvl_req_off");
      check(2, F_VALID, 32'd0, "lvl_valid_off");
      tick();
      tick();
    end
    fiqen = 1'b1;
    en    = '1;
    repeat (3) tick();

    // ---------------- edge + acknowledge on sources 3 and 7 ----------------
    sel = 32'h88;
    src = 32'h88;
    check(2, F_RAW, 32'h88, "ack_raw_both");
    check(3, F_REQ, 32'd1,  "ack_req_first");
    check(3, F_ID,  32'd3,  "ack_id_first");
    tick();
    src = '0;
    tick();
    tick();
    ack = 1'b1;
    check(1, F_RAW, 32'h80, "ack_raw_after1");
    check(1, F_ID,  32'd3,  "ack_id_stale");
    check(2, F_REQ, 32'd1,  "ack_req_second");
    check(2, F_ID,  32'd7,  "ack_id_second");
    tick();
    ack = 1'b0;
    tick();
    ack = 1'b1;
    check(1, F_RAW, 32'd0, "ack_raw_after2");
    check(2, F_REQ, 32'd0, "ack_req_drop");
    check(2, F_ID,  32'd0, "ack_id_drop");
    tick();
    ack = 1'b0;
    repeat (2) tick();

    // ---------------- clear vs new edge on source 5 ------------------------
    sel = 32'h20;
    src = 32'h20;
    tick();
    src = '0;
    tick();
    src = 32'h20;
    tick();
    check(0, F_REQ, 32'd1, "clr_req_pend");
    check(0, F_ID,  32'd5, "clr_id_pend");
    src = '0;
    clr = 32'h20;
    check(1, F_RAW, 32'h20, "clr_set_wins");
    check(2, F_REQ, 32'd1,  "clr_req_kept");
    check(2, F_ID,  32'd5,  "clr_id_kept");
    tick();
    clr = '0;
    tick();
    clr = 32'h20;
    check(1, F_RAW,   32'd0, "clr_plain_raw");
    check(2, F_REQ,   32'd0, "clr_plain_req");
    check(2, F_VALID, 32'd0, "clr_plain_valid");
    tick();
    clr = '0;
    repeat (2) tick();

    // ---------------- masking of a pending edge on source 9 -----------------
    sel = 32'h200;
    src = 32'h200;
    tick();
    src = '0;
    en  = ~32'h200;
    for (int k = 1; k <= 10; k++) begin
      check(k, F_RAW, 32'h200, "mask_raw");
      check(k, F_REQ, 32'd0,   "mask_req");
    end
    check(1, F_STAT, 32'd0, "mask_stat");
    repeat (10) tick();
    en    = '1;
    fiqen = 1'b0;
    check(1, F_REQ,   32'd0, "unmask_req_gated");
    check(1, F_VALID, 32'd1, "unmask_valid");
    check(1, F_ID,    32'd9, "unmask_id");
    tick();
    // acknowledge while no request is presented must be ignored
    ack = 1'b1;
    check(1, F_RAW, 32'h200, "ack_ignored_raw");
    tick();
    ack   = 1'b0;
    fiqen = 1'b1;
    check(1, F_REQ, 32'd1, "reenable_req");
    check(1, F_ID,  32'd9, "reenable_id");
    tick();

    // ---------------- mode changes -----------------------------------------
    sel = '0;
    tick();
    sel = 32'h200;
    check(0, F_RAW, 32'd0, "mode_discard");
    sel = '0;
    src = 32'h200;
    repeat (3) tick();
    sel = 32'h200;
    check(0, F_RAW, 32'd0, "mode_no_edge0");
    check(1, F_RAW, 32'd0, "mode_no_edge1");
    check(2, F_RAW, 32'd0, "mode_no_edge2");
    repeat (3) tick();
    src = '0;
    sel = '0;
    repeat (2) tick();

    // ---------------- reset mid-operation ----------------------------------
    sel = 32'h08;
    src = 32'h08;
    tick();
    src = '0;
    tick();
    tick();
    check(0, F_REQ, 32'd1, "midrst_req_pend");
    rstn = 1'b0;
    tick();
    check(0, F_REQ, 32'd0, "midrst_req");
    check(0, F_RAW, 32'd0, "midrst_raw");
    rstn = 1'b1;
    tick();
    tick();
    check(0, F_RAW, 32'd0, "postrst_raw");
    check(0, F_REQ, 32'd0, "postrst_req");

    repeat (3) tick();
    // expectations the monitor never reached count as misses
    while (sb.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: not compared, expected %h at edge %0d",
               sb[0].name, sb[0].exp, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (n_miss == 0) $display("PASS");
    else             $display("FAIL");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/vic_fiq_ctrl.md
# vic_fiq_ctrl

Parametrised FIQ controller for the vectored interrupt controller. It generalises the fixed 32-bit, enable-gated FIQ request path. It adds a per-source level/edge mode, registered source sampling, sticky edge latches with software clear and acknowledge, and a registered request with a lowest-index source ID. It sits between the raw interrupt sources or register file and the core's nFIQ logic.

## Interface
- NUM_SRC, 32, number of interrupt sources (2..32)
- ID_W, $clog2(NUM_SRC), width of the source-ID output (derived; do not override)

- HCLK  in  1  single clock; all state updates on rising edge
- HRESETn  in  1  reset, synchronous, active-low
- VICIntSource  in  NUM_SRC  raw interrupt lines, active-high, synchronous to HCLK
- VICEdgeSel  in  NUM_SRC  per-source mode: 1 = rising-edge, 0 = level
- VICIntEnable  in  NUM_SRC  per-source mask, 1 = enabled
- VICFIQEn  in  1  global FIQ enable
- VICIntClear  in  NUM_SRC  one-cycle write-1-to-clear pulses for edge latches
- VICFIQAck  in  1  acknowledge of the currently reported source
- VICRawStatus  out  NUM_SRC  unmasked pending status
- VICFIQStatus  out  NUM_SRC  VICRawStatus & VICIntEnable
- VICFIQRequest  out  1  registered FIQ request
- VICFIQValid  out  1  registered: any masked source pending
- VICFIQId  out  ID_W  registered lowest-index pending source

## Operation
- Sampling: src_q <= VICIntSource; src_qq <= src_q, every cycle.
- Edge latch edge_l[i], edge mode only:
  - set when src_q[i] & ~src_qq[i]
  - cleared by VICIntClear[i]
  - cleared by an acknowledge hit, where VICFIQAck & VICFIQRequest & (VICFIQId == i)
  - set has priority over clear in the same cycle, so a new edge is never lost
- Level mode (VICEdgeSel[i]=0): edge_l[i] is forced to 0 at the next edge. VICIntClear and acknowledge have no effect on the source.
- VICRawStatus[i] (combinational from registers) = VICEdgeSel[i] ? edge_l[i] : src_q[i].
- VICFIQStatus = VICRawStatus & VICIntEnable (combinational).
- Registered outputs, updated every cycle:
  - VICFIQValid <= |VICFIQStatus
  - VICFIQId <= index of lowest set bit of VICFIQStatus, or 0 if none
  - VICFIQRequest <= VICFIQEn & |VICFIQStatus
- Disabling a source (enable or global) masks it only. An edge latch stays pending and reasserts when the source is re-enabled.
- VICFIQAck while VICFIQRequest=0 is ignored.

## Timing
- Reset (HRESETn=0 at a rising edge) clears src_q, src_qq, all edge_l, VICFIQRequest, VICFIQValid and VICFIQId to 0. VICRawStatus and VICFIQStatus are therefore 0 in the cycle after reset.
- Reset mid-operation discards all pending edges.
- A source already high at reset release is seen as a rising edge (src_qq = 0) and latches.
- Level latency: source high before edge k -> src_q at k -> VICFIQRequest at k+1 (2 edges).
- Edge latency: src_q at k -> edge_l at k+1 -> VICFIQRequest at k+2 (3 edges).
- Level deassert: VICFIQRequest falls 2 edges after the source falls.
- An edge pulse of 1 HCLK cycle is captured. Pulses shorter than 1 cycle are not guaranteed to be captured.
- Acknowledge at edge k clears the latch at k. VICFIQRequest/VICFIQId move to the next pending source, or drop, at k+1. The bench must not issue a second acknowledge at k+1, because VICFIQId is stale for one cycle.
- Mode change 1->0 discards a pending latch at the next edge. Mode change 0->1 while the source is held high does not generate an edge.

## Test plan
- Reset: hold HRESETn=0 with all sources high for 3 cycles -> VICFIQRequest=0, VICFIQId=0, VICRawStatus=0. After release, with VICEdgeSel=all 1 and enables on, VICFIQRequest=1 on the 3rd edge, with VICFIQId=0.
- Level path (NUM_SRC=32): VICEdgeSel=0, VICIntEnable=32'h4a0000a4, VICFIQEn toggled with source 32'h4a0000a4 pulsed 1 cycle on / 2 off. Expected: VICFIQStatus=32'h4a0000a4 while high, VICFIQId=2, VICFIQRequest follows the pulse delayed 2 edges and only while VICFIQEn=1.
- Edge + acknowledge: bits 3 and 7 edge mode, both pulsed high 1 cycle in the same cycle. Expected: Request with Id=3; acknowledge -> Id=7 next cycle; acknowledge -> Request=0.
- Clear vs new edge: VICIntClear[5] asserted in the same cycle a new edge on src 5 latches. Expected: latch stays set and Request remains 1.
- Masking: edge latch on bit 9 pending, VICIntEnable[9]=0 for 10 cycles. Expected: Request=0 and VICRawStatus[9]=1; re-enable -> Request=1 one edge later, Id=9.
- Parameter sweep: NUM_SRC=2 and NUM_SRC=17. Expected: ID_W=1 and 5 respectively, and highest source alone pending gives Id=NUM_SRC-1.
